// File: rtl/inst_mem_pkg.sv
// Shared types and constants for the instruction-memory responder.
//   NOP         : instruction returned for erroneous requests
//   DEPTH_DEF   : default array depth in words
//   ADDR_W_DEF  : byte-address width carried in responses
//   resp_t      : queued response payload {inst, addr, err}
package inst_mem_pkg;

    localparam int unsigned DEPTH_DEF  = 64;
    localparam int unsigned ADDR_W_DEF = 32;
    localparam int unsigned INST_W     = 32;

    localparam logic [INST_W-1:0] NOP = 32'h0;

    typedef struct packed {
        logic [INST_W-1:0]     inst;
        logic [ADDR_W_DEF-1:0] addr;
        logic                  err;
    } resp_t;

endpackage

// File: rtl/inst_mem_responder_resp_fifo2.sv
// Two-entry in-order response queue; head entry is always slot 0.
// Ports:
//   clk, rst_n : clock, async active-low reset
//   push, din  : enqueue din (ignored when full unless popping)
//   pop        : dequeue head (caller gates with count != 0)
//   flush      : drop everything; overrides push and pop
//   count      : number of valid entries (0..2)
//   head       : slot 0 contents; all-zero when empty
module resp_fifo2
    import inst_mem_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       push,
    input  logic       pop,
    input  logic       flush,
    input  resp_t      din,
    output logic [1:0] count,
    output resp_t      head
);

    resp_t slot0;
    resp_t slot1;

    assign head = slot0;

    // Vacated slots are zeroed so the head reads as all-zero when empty.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot0 <= '0;
            slot1 <= '0;
            count <= 2'd0;
        end else if (flush) begin
            slot0 <= '0;
            slot1 <= '0;
            count <= 2'd0;
        end else if (push && pop) begin
            if (count == 2'd2) begin
                slot0 <= slot1;
                slot1 <= din;
            end else begin
                slot0 <= din;
            end
        end else if (pop) begin
            slot0 <= (count == 2'd2) ? slot1 : '0;
            slot1 <= '0;
            count <= count - 2'd1;
        end else if (push && count != 2'd2) begin
            if (count == 2'd0) begin
                slot0 <= din;
            end else begin
                slot1 <= din;
            end
            count <= count + 2'd1;
        end
    end

endmodule

// File: rtl/inst_mem_responder.sv
// Instruction-memory responder for the fetch stage.
// Accepts word-aligned PC reads over valid/ready, returns {inst, pc, err}
// through a 2-entry queue; flush drops queued responses; ld_* writes the
// array at run time.
// Ports:
//   clk, rst_n                       : clock, async active-low reset
//   req_valid/req_ready/req_addr     : request handshake, byte PC
//   resp_valid/resp_ready            : response handshake
//   resp_inst/resp_addr/resp_err     : head response (zero when empty)
//   flush                            : discard queued responses
//   ld_en/ld_addr/ld_data            : array write port
module inst_mem_responder
    import inst_mem_pkg::*;
#(
    parameter int unsigned DEPTH  = DEPTH_DEF,
    parameter int unsigned ADDR_W = ADDR_W_DEF
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic [ADDR_W-1:0]        req_addr,
    output logic                     resp_valid,
    input  logic                     resp_ready,
    output logic [31:0]              resp_inst,
    output logic [ADDR_W-1:0]        resp_addr,
    output logic                     resp_err,
    input  logic                     flush,
    input  logic                     ld_en,
    input  logic [$clog2(DEPTH)-1:0] ld_addr,
    input  logic [31:0]              ld_data
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [31:0] mem [DEPTH];
    logic [1:0]  count;
    resp_t       head;
    resp_t       new_entry;
    logic        accept;
    logic        pop;
    logic        bad;

    // Program load port; array has no reset so contents survive rst_n.
    always_ff @(posedge clk) begin
        if (ld_en) begin
            mem[ld_addr] <= ld_data;
        end
    end

    // Ready depends only on local state, never on resp_ready.
    assign req_ready = rst_n & ~flush & (count != 2'd2);
    assign accept    = req_valid & req_ready;
    assign pop       = resp_valid & resp_ready;

    // Misaligned or beyond the array: return NOP flagged as error.
    assign bad = (req_addr[1:0] != 2'b00) || (req_addr >= ADDR_W'(4 * DEPTH));

    always_comb begin
        new_entry      = '0;
        new_entry.addr = ADDR_W_DEF'(req_addr);
        new_entry.err  = bad;
        new_entry.inst = bad ? NOP : mem[req_addr[AW+1:2]];
    end

    resp_fifo2 u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (accept),
        .pop   (pop),
        .flush (flush),
        .din   (new_entry),
        .count (count),
        .head  (head)
    );

    assign resp_valid = (count != 2'd0);
    assign resp_inst  = head.inst;
    assign resp_addr  = ADDR_W'(head.addr);
    assign resp_err   = head.err;

endmodule

// File: tb/tb_inst_mem_responder.sv
module tb_inst_mem_responder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_inst;
    logic [31:0] resp_addr;
    logic        resp_err;
    logic        flush;
    logic        ld_en;
    logic [5:0]  ld_addr;
    logic [31:0] ld_data;

    int total = 0;
    int bad   = 0;

    inst_mem_responder #(.DEPTH(64), .ADDR_W(32)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_addr   (req_addr),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_inst  (resp_inst),
        .resp_addr  (resp_addr),
        .resp_err   (resp_err),
        .flush      (flush),
        .ld_en      (ld_en),
        .ld_addr    (ld_addr),
        .ld_data    (ld_data)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst_n = 1'b0; req_valid = 1'b0; req_addr = '0; resp_ready = 1'b0;
        flush = 1'b0; ld_en = 1'b0; ld_addr = '0; ld_data = '0;
        #2;
        check("rst_valid", 32'(resp_valid), 32'd0);
        check("rst_inst",  resp_inst, 32'd0);
        check("rst_addr",  resp_addr, 32'd0);
        check("rst_err",   32'(resp_err), 32'd0);
        check("rst_ready", 32'(req_ready), 32'd0);
        step();
        rst_n = 1'b1;
        #1;
        check("ready_after_rst", 32'(req_ready), 32'd1);

        // program words 0..3 = A0..A3, word 5 = A5
        for (int i = 0; i < 6; i++) begin
            ld_en = 1'b1; ld_addr = 6'(i); ld_data = 32'hA0 + 32'(i);
            step();
        end
        ld_en = 1'b0;

        // back-to-back streaming with resp_ready high
        resp_ready = 1'b1; req_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            req_addr = 32'(4 * i);
            step();
            check("stream_valid", 32'(resp_valid), 32'd1);
            check("stream_inst",  resp_inst, 32'hA0 + 32'(i));
            check("stream_addr",  resp_addr, 32'(4 * i));
        end
        req_valid = 1'b0;
        step();
        check("stream_drained", 32'(resp_valid), 32'd0);

        // back-pressure: two accepts fill the queue
        resp_ready = 1'b0; req_valid = 1'b1; req_addr = 32'd0;
        step();
        req_addr = 32'd4;
        step();
        check("bp_full_ready", 32'(req_ready), 32'd0);
        check("bp_head0", resp_inst, 32'hA0);
        req_addr = 32'd8;
        step();
        check("bp_stall_ready", 32'(req_ready), 32'd0);
        check("bp_head_stable", resp_inst, 32'hA0);
        resp_ready = 1'b1;
        #1;
        check("bp_head_before_pop", resp_inst, 32'hA0);
        step();
        check("bp_pop1", resp_inst, 32'hA1);
        check("bp_ready_again", 32'(req_ready), 32'd1);
        step();
        check("bp_pop2_inst", resp_inst, 32'hA2);
        check("bp_pop2_addr", resp_addr, 32'd8);
        req_valid = 1'b0;
        step();
        check("bp_empty", 32'(resp_valid), 32'd0);

        // flush with resp_ready high discards both entries
        resp_ready = 1'b0; req_valid = 1'b1; req_addr = 32'd0;
        step();
        req_addr = 32'd4;
        step();
        req_valid = 1'b0; flush = 1'b1; resp_ready = 1'b1;
        #1;
        check("flush_ready_low", 32'(req_ready), 32'd0);
        step();
        flush = 1'b0;
        check("flush_valid", 32'(resp_valid), 32'd0);
        check("flush_inst",  resp_inst, 32'd0);
        req_valid = 1'b1; req_addr = 32'd20;
        step();
        check("post_flush_inst", resp_inst, 32'hA5);
        check("post_flush_addr", resp_addr, 32'd20);
        check("post_flush_err",  32'(resp_err), 32'd0);

        // error responses
        req_addr = 32'd5;
        step();
        check("mis_inst", resp_inst, 32'd0);
        check("mis_err",  32'(resp_err), 32'd1);
        check("mis_addr", resp_addr, 32'd5);
        req_addr = 32'd256;
        step();
        check("oor_inst", resp_inst, 32'd0);
        check("oor_err",  32'(resp_err), 32'd1);
        check("oor_addr", resp_addr, 32'd256);
        req_addr = 32'd252;
        step();
        check("last_word_err", 32'(resp_err), 32'd0);
        req_valid = 1'b0;
        step();

        // load and read of the same word in one cycle returns old data
        ld_en = 1'b1; ld_addr = 6'd2; ld_data = 32'hBEEF;
        req_valid = 1'b1; req_addr = 32'd8;
        step();
        ld_en = 1'b0;
        check("ld_same_cycle_old", resp_inst, 32'hA2);
        step();
        check("ld_new_data", resp_inst, 32'hBEEF);
        req_valid = 1'b0;
        step();

        // async reset with two entries queued
        resp_ready = 1'b0; req_valid = 1'b1; req_addr = 32'd0;
        step();
        req_addr = 32'd4;
        step();
        req_valid = 1'b0;
        check("pre_rst_valid", 32'(resp_valid), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_valid", 32'(resp_valid), 32'd0);
        check("async_rst_ready", 32'(req_ready), 32'd0);
        check("async_rst_inst",  resp_inst, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("rel_ready", 32'(req_ready), 32'd1);
        check("rel_empty", 32'(resp_valid), 32'd0);
        resp_ready = 1'b1; req_valid = 1'b1; req_addr = 32'd0;
        step();
        check("mem_preserved", resp_inst, 32'hA0);
        req_valid = 1'b0;
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
